// File: rtl/stdout_uart_tx_pkg.sv
// Shared definitions for the stdout UART sink: transmitter FSM states and frame geometry.
package stdout_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_FRAME_BITS = 10;

endpackage

// File: rtl/stdout_uart_tx_if.sv
// Core-side stdout handshake: byte plus present flag one way, enable/backpressure the other.
interface stdout_uart_tx_if;

    logic [7:0] stdout;
    logic       stdout_en;
    logic       cpu_en;

    modport master (output stdout, output stdout_en, input cpu_en);
    modport slave  (input stdout, input stdout_en, output cpu_en);

endinterface

// File: rtl/stdout_uart_tx_sync_fifo.sv
// Synchronous FIFO with a registered head-of-queue output and separately tracked count.
module sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [WIDTH-1:0]      dout_q, dout_d;
    logic                  do_push, do_pop;

    always_comb begin
        do_pop   = pop & (count_q != '0);
        do_push  = push & ((count_q != CNT_W'(DEPTH)) | do_pop);
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(do_pop);
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(do_push);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        // Head after this edge: forward din when it lands in the slot becoming the head.
        if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            dout_d = din;
        end else begin
            dout_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    assign dout  = dout_q;
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/stdout_uart_tx.sv
// Buffers bytes from the core's stdout port and sends them as 8N1 UART frames, throttling the core via cpu_en.
module stdout_uart_tx
    import stdout_uart_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV         = 16,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned FIFO_ADDR_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    stdout_uart_tx_if.slave            core,
    input  logic                       run,
    output logic                       tx,
    output logic                       busy,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_count
);

    localparam int unsigned CNT_W  = FIFO_ADDR_WIDTH + 1;
    localparam int unsigned BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_state_e       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              cpu_en_q, cpu_en_d;

    logic              fifo_push, fifo_pop, fifo_shift;
    logic [7:0]        fifo_dout;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_empty, fifo_full;
    logic [CNT_W-1:0]  count_next;
    logic              baud_last;

    // cpu_en_q already implies room; the full term only documents that no overflow can occur.
    assign fifo_push = core.stdout_en & cpu_en_q & ~fifo_full;

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (core.stdout),
        .dout  (fifo_dout),
        .count (fifo_cnt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        count_next = fifo_cnt + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        cpu_en_d   = run & (count_next != CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            cpu_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            cpu_en_q  <= cpu_en_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        fifo_pop   = 1'b0;
        fifo_shift = 1'b0;
        baud_last  = (baud_q == BAUD_LAST);
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_d   = ST_START;
                    baud_d    = '0;
                    bit_idx_d = '0;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d  = bit_idx_q + 3'd1;
                        fifo_shift = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        state_d   = ST_START;
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shreg_d = shreg_q;
        if (fifo_pop) begin
            shreg_d = fifo_dout;
        end else if (fifo_shift) begin
            shreg_d = {1'b0, shreg_q[7:1]};
        end
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[0];
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign core.cpu_en = cpu_en_q;
    assign tx          = tx_q;
    assign busy        = busy_q;
    assign fifo_count  = fifo_cnt;

endmodule
